cache_fill_arbiter: RTL and testbench
=====================================

CACHE_FILL_ARBITER -- requirements
Module: cache_fill_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: byte-address width.
REQ-002 SHALL have parameter WORDS, default 8: 16-bit words per cache block (block = 16 bytes).
REQ-003 SHALL have ports clk (in, 1) and rst_n (in, 1): one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port i_miss (in, 1): I-cache miss request, held until i_fill_done.
REQ-005 SHALL have port i_miss_addr (in, ADDR_W): I-cache miss byte address.
REQ-006 SHALL have port d_miss (in, 1): D-cache miss request, held until d_fill_done.
REQ-007 SHALL have port d_miss_addr (in, ADDR_W): D-cache miss byte address.
REQ-008 SHALL have port mem_en (out, 1): read strobe to shared main memory.
REQ-009 SHALL have port mem_addr (out, ADDR_W): word address issued to memory.
REQ-010 SHALL have port mem_data_valid (in, 1): memory read data valid, fixed 4-cycle latency, pipelined.
REQ-011 SHALL have port mem_data (in, 16): memory read data.
REQ-012 SHALL have ports fill_data (out, 16) and fill_word (out, 3): returned word and its index in the block.
REQ-013 SHALL have ports i_fill_we and d_fill_we (out, 1 each): write-enable to the owning cache's data array.
REQ-014 SHALL have ports i_fill_done and d_fill_done (out, 1 each): one-cycle completion pulse per cache.
REQ-015 SHALL have ports busy (out, 1): fill in progress; owner (out, 1): 0 = I-cache, 1 = D-cache.

Function
REQ-016 SHALL implement states IDLE, ISSUE, DRAIN.
REQ-017 IDLE: grant on the rising edge on which any miss is high; latch owner and base = {miss_addr[ADDR_W-1:4], 4'h0}; go to ISSUE.
REQ-018 ISSUE: mem_en = 1 for exactly WORDS consecutive cycles; mem_addr = base + 2*issue_cnt; issue_cnt counts 0..7; after the 8th issue go to DRAIN.
REQ-019 Each cycle mem_data_valid = 1 in ISSUE or DRAIN: fill_data = mem_data, fill_word = recv_cnt, owner's fill_we = 1, recv_cnt increments; all combinational same-cycle.
REQ-020 On the 8th valid word, owner's fill_done pulses in the same cycle as its fill_we; next state is IDLE.
REQ-021 Grant-to-done latency SHALL be 12 cycles: first mem_en is the cycle after grant, last data is 4 cycles after the last issue.
REQ-022 Back-to-back fills SHALL have exactly one IDLE cycle between done and the next mem_en-bearing ISSUE cycle.
REQ-023 mem_data_valid in IDLE, or beyond the 8th word, SHALL be ignored; no fill_we, no done.
REQ-024 A miss deasserting mid-fill SHALL NOT abort the fill; the block completes.
REQ-025 Base + 14 SHALL NOT carry out of the block (0xFFF0 issues 0xFFF0..0xFFFE, no wrap).
REQ-026 The non-owner's fill_we and fill_done SHALL stay 0 throughout a fill.
REQ-027 busy = 1 in ISSUE and DRAIN; 0 in IDLE.
REQ-028 Simultaneous misses in IDLE SHALL be resolved per REQ-032/REQ-033.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, counters 0, owner 0, round-robin pointer to I, and all outputs 0.
REQ-030 Reset mid-fill SHALL abort with no done pulse; outstanding memory data after release SHALL be ignored per REQ-023.

Configuration
REQ-031 Macro ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-032 Undefined: fixed priority, D-cache wins every tie.
REQ-033 Defined: round-robin; on a tie, grant the cache not granted last; after reset D wins the first tie.

Structure
REQ-034 Shared package cache_pkg SHALL hold the state enum, WORDS, BLOCK_OFF_W = 4, and the OWNER_I/OWNER_D constants.
REQ-035 One sub-module, word_counter (3-bit, clear/increment, terminal flag), SHALL be instantiated twice, for issue_cnt and recv_cnt.

Verification
REQ-036 i_miss, addr 0x1236, alone -> mem_addr 0x1230..0x123E over 8 cycles; 8 i_fill_we, fill_word 0..7; i_fill_done 12 cycles after grant.
REQ-037 i_miss and d_miss together, macro undefined -> D filled first, I granted 1 cycle after d_fill_done; macro defined, post-reset -> same order, and the next tie -> I first.
REQ-038 d_miss, addr 0xFFF8 -> mem_addr 0xFFF0..0xFFFE, no wrap to 0x0000.
REQ-039 rst_n low at the 5th issue cycle -> outputs 0 immediately; 4 trailing mem_data_valid pulses -> no fill_we or done.
REQ-040 Spurious mem_data_valid in IDLE with mem_data 0xBEEF -> no fill_we; d_miss dropped mid-fill -> all 8 words still written and d_fill_done pulses.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg
//   Shared definitions for the cache fill arbiter: FSM state encoding,
//   block geometry and the owner encoding driven on the 'owner' output.
`timescale 1ns/1ps
package cache_pkg;

  // 16-bit words per 16-byte cache block.
  localparam int WORDS       = 8;
  // Byte-offset bits inside a block.
  localparam int BLOCK_OFF_W = 4;

  // Owner encoding: 0 = I-cache, 1 = D-cache.
  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } fill_state_e;

endpackage

// File: rtl/word_counter.sv
// word_counter
//   3-bit word index counter with synchronous clear and increment, plus a
//   terminal flag that is high while the count equals TERM.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     clr        : clear to 0 (wins over inc)
//     inc        : increment by one (wraps)
//     cnt        : current count
//     term       : cnt == TERM
`timescale 1ns/1ps
module word_counter #(
  parameter logic [2:0] TERM = 3'd7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [2:0] cnt,
  output logic       term
);

  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 3'd0;
    end else if (inc) begin
      cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign term = (cnt_q == TERM);

endmodule

// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter
//   Arbitrates I-cache and D-cache miss requests onto one shared, pipelined
//   main-memory read port (fixed 4-cycle read latency) and returns the eight
//   16-bit words of the 16-byte block to the owning cache.
//
//   Optional macro ARB_ROUND_ROBIN_EN:
//     undefined : fixed priority, D-cache wins every tie
//     defined   : round-robin, a tie goes to the cache not granted last;
//                 after reset the pointer says "I granted last", so D wins
//                 the first tie
//
//   Ports:
//     clk, rst_n                 : clock, asynchronous active-low reset
//     i_miss, i_miss_addr        : I-cache miss request (held until done)
//     d_miss, d_miss_addr        : D-cache miss request (held until done)
//     mem_en, mem_addr           : memory read strobe / word address
//     mem_data_valid, mem_data   : memory read data return
//     fill_data, fill_word       : returned word and its index in the block
//     i_fill_we, d_fill_we       : write enables to the owning data array
//     i_fill_done, d_fill_done   : one-cycle completion pulses
//     busy, owner                : fill in progress, current owner (0=I,1=D)
`timescale 1ns/1ps
module cache_fill_arbiter #(
  parameter int ADDR_W = 16,
  parameter int WORDS  = cache_pkg::WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_data_valid,
  input  logic [15:0]       mem_data,
  output logic [15:0]       fill_data,
  output logic [2:0]        fill_word,
  output logic              i_fill_we,
  output logic              d_fill_we,
  output logic              i_fill_done,
  output logic              d_fill_done,
  output logic              busy,
  output logic              owner
);

  import cache_pkg::*;

  localparam int         BLK_W    = ADDR_W - BLOCK_OFF_W;
  localparam logic [2:0] LAST_IDX = 3'(WORDS - 1);

  fill_state_e      state_q, state_d;
  logic             owner_q, owner_d;
  logic [BLK_W-1:0] blk_q, blk_d;     // block number; byte offset is implicitly 0

  logic       grant;
  logic       grant_owner;
  logic       accept;
  logic [2:0] issue_cnt;
  logic       issue_last;
  logic [2:0] recv_cnt;
  logic       recv_last;
  logic       in_idle;
  logic       fill_done;

  // Byte-offset bits of the miss addresses never reach memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_miss_addr[BLOCK_OFF_W-1:0], d_miss_addr[BLOCK_OFF_W-1:0]};

  assign in_idle = (state_q == IDLE);
  assign grant   = in_idle && (i_miss || d_miss);

`ifdef ARB_ROUND_ROBIN_EN
  // Owner of the most recent grant; a tie goes to the other cache.
  logic last_q, last_d;

  assign grant_owner = d_miss && (!i_miss || (last_q == OWNER_I)) ? OWNER_D : OWNER_I;

  always_comb begin
    last_d = last_q;
    if (grant) begin
      last_d = grant_owner;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= OWNER_I;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign grant_owner = d_miss ? OWNER_D : OWNER_I;
`endif

  // Returned data only counts while a fill is open; anything arriving in
  // IDLE (spurious, or leftovers from a fill cut short by reset) is dropped.
  assign accept    = mem_data_valid && !in_idle;
  assign fill_done = accept && recv_last;

  word_counter #(.TERM(LAST_IDX)) u_issue_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (in_idle),
    .inc   (state_q == ISSUE),
    .cnt   (issue_cnt),
    .term  (issue_last)
  );

  word_counter #(.TERM(LAST_IDX)) u_recv_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (in_idle),
    .inc   (accept),
    .cnt   (recv_cnt),
    .term  (recv_last)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    blk_d   = blk_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = ISSUE;
          owner_d = grant_owner;
          blk_d   = (grant_owner == OWNER_D) ? d_miss_addr[ADDR_W-1:BLOCK_OFF_W]
                                             : i_miss_addr[ADDR_W-1:BLOCK_OFF_W];
        end
      end
      ISSUE: begin
        if (issue_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Nothing to do but wait for the last word.
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // The final word closes the fill from either ISSUE or DRAIN.
    if (fill_done) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWNER_I;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      blk_q   <= blk_d;
    end
  end

  // Word address: block number, word index, byte 0. Concatenation rather
  // than addition keeps the sequence inside the block (no carry out).
  assign mem_en   = (state_q == ISSUE);
  assign mem_addr = mem_en ? {blk_q, issue_cnt, 1'b0} : '0;

  assign fill_data   = accept ? mem_data : 16'h0000;
  assign fill_word   = accept ? recv_cnt : 3'd0;
  assign i_fill_we   = accept && (owner_q == OWNER_I);
  assign d_fill_we   = accept && (owner_q == OWNER_D);
  assign i_fill_done = fill_done && (owner_q == OWNER_I);
  assign d_fill_done = fill_done && (owner_q == OWNER_D);
  assign busy        = !in_idle;
  assign owner       = owner_q;

endmodule

// File: tb/tb_cache_fill_arbiter.sv
`timescale 1ns/1ps
module tb_cache_fill_arbiter;

  localparam logic [15:0] KEY = 16'hA5C3;  // memory returns addr ^ KEY

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_miss = 1'b0;
  logic [15:0] i_miss_addr = 16'h0000;
  logic        d_miss = 1'b0;
  logic [15:0] d_miss_addr = 16'h0000;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic        mem_data_valid;
  logic [15:0] mem_data;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done, busy, owner;

  // memory model and spurious-data injection
  logic        mdl_valid = 1'b0;
  logic [15:0] mdl_data  = 16'h0000;
  logic        inj_valid = 1'b0;
  logic [15:0] inj_data  = 16'h0000;

  assign mem_data_valid = mdl_valid | inj_valid;
  assign mem_data       = inj_valid ? inj_data : mdl_data;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  cache_fill_arbiter #(.ADDR_W(16), .WORDS(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_miss         (i_miss),
    .i_miss_addr    (i_miss_addr),
    .d_miss         (d_miss),
    .d_miss_addr    (d_miss_addr),
    .mem_en         (mem_en),
    .mem_addr       (mem_addr),
    .mem_data_valid (mem_data_valid),
    .mem_data       (mem_data),
    .fill_data      (fill_data),
    .fill_word      (fill_word),
    .i_fill_we      (i_fill_we),
    .d_fill_we      (d_fill_we),
    .i_fill_done    (i_fill_done),
    .d_fill_done    (d_fill_done),
    .busy           (busy),
    .owner          (owner)
  );

  // Pipelined memory: a read issued in cycle k returns valid data in k+4.
  initial begin : mem_model
    logic        pipe_en   [4];
    logic [15:0] pipe_addr [4];
    logic        s_en;
    logic [15:0] s_addr;
    for (int k = 0; k < 4; k++) begin
      pipe_en[k]   = 1'b0;
      pipe_addr[k] = 16'h0000;
    end
    forever begin
      @(negedge clk);
      s_en   = mem_en;
      s_addr = mem_addr;
      @(posedge clk);
      #1;
      for (int k = 3; k > 0; k--) begin
        pipe_en[k]   = pipe_en[k-1];
        pipe_addr[k] = pipe_addr[k-1];
      end
      pipe_en[0]   = s_en;
      pipe_addr[0] = s_addr;
      mdl_valid    = pipe_en[3];
      mdl_data     = pipe_addr[3] ^ KEY;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"},      {31'd0, busy},      32'd0);
    check({tag, " mem_en"},    {31'd0, mem_en},    32'd0);
    check({tag, " mem_addr"},  {16'd0, mem_addr},  32'd0);
    check({tag, " fill_we"},   {30'd0, i_fill_we, d_fill_we},     32'd0);
    check({tag, " fill_done"}, {30'd0, i_fill_done, d_fill_done}, 32'd0);
    check({tag, " owner"},     {31'd0, owner},     32'd0);
    check({tag, " fill_data"}, {16'd0, fill_data}, 32'd0);
    check({tag, " fill_word"}, {29'd0, fill_word}, 32'd0);
  endtask

  // Called at the negedge of the cycle in which the request is (first) seen
  // in IDLE; walks the 12 cycles that follow the grant.
  task automatic do_fill(input string tag, input logic own, input logic [15:0] base,
                         input bit drop_mid);
    logic [15:0] exp_addr;
    logic        we_own, we_oth, dn_own, dn_oth;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      we_own = own ? d_fill_we   : i_fill_we;
      we_oth = own ? i_fill_we   : d_fill_we;
      dn_own = own ? d_fill_done : i_fill_done;
      dn_oth = own ? i_fill_done : d_fill_done;
      check({tag, " busy"},   {31'd0, busy},   32'd1);
      check({tag, " owner"},  {31'd0, owner},  {31'd0, own});
      check({tag, " mem_en"}, {31'd0, mem_en}, (c <= 8) ? 32'd1 : 32'd0);
      if (c <= 8) begin
        exp_addr = base + 16'(2 * (c - 1));
        check({tag, " mem_addr"}, {16'd0, mem_addr}, {16'd0, exp_addr});
      end
      check({tag, " owner_we"}, {31'd0, we_own}, (c >= 5) ? 32'd1 : 32'd0);
      check({tag, " other_we"}, {31'd0, we_oth}, 32'd0);
      if (c >= 5) begin
        exp_addr = base + 16'(2 * (c - 5));
        check({tag, " fill_word"}, {29'd0, fill_word}, 32'(c - 5));
        check({tag, " fill_data"}, {16'd0, fill_data}, {16'd0, exp_addr ^ KEY});
      end
      check({tag, " owner_done"}, {31'd0, dn_own}, (c == 12) ? 32'd1 : 32'd0);
      check({tag, " other_done"}, {31'd0, dn_oth}, 32'd0);
      if (drop_mid && c == 4) d_miss = 1'b0;
      if (c == 12) begin
        if (own) d_miss = 1'b0;
        else     i_miss = 1'b0;
      end
    end
    $display("[TB] fill %s owner=%0d base=0x%04h done", tag, own, base);
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, " idle busy"},   {31'd0, busy},   32'd0);
    check({tag, " idle mem_en"}, {31'd0, mem_en}, 32'd0);
  endtask

  logic first_own;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    $display("[TB] reset values checked");
    rst_n = 1'b1;

    // I-cache alone, unaligned address
    @(negedge clk);
    i_miss = 1'b1; i_miss_addr = 16'h1236;
    do_fill("i_alone", 1'b0, 16'h1230, 1'b0);
    check_idle("i_alone");

    // fresh reset, then a tie: D first, I one cycle after d_fill_done
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    i_miss = 1'b1; i_miss_addr = 16'h0104;
    d_miss = 1'b1; d_miss_addr = 16'h4A5C;
    do_fill("tie1_d", 1'b1, 16'h4A50, 1'b0);
    check_idle("tie1_gap");
    do_fill("tie1_i", 1'b0, 16'h0100, 1'b0);
    check_idle("tie1_i");

    // top-of-space block: no wrap
    d_miss = 1'b1; d_miss_addr = 16'hFFF8;
    do_fill("d_top", 1'b1, 16'hFFF0, 1'b0);
    check_idle("d_top");

    // second tie, after D was granted last
`ifdef ARB_ROUND_ROBIN_EN
    first_own = 1'b0;
`else
    first_own = 1'b1;
`endif
    i_miss = 1'b1; i_miss_addr = 16'h333A;
    d_miss = 1'b1; d_miss_addr = 16'h7778;
    if (first_own) begin
      do_fill("tie2_d", 1'b1, 16'h7770, 1'b0);
      check_idle("tie2_gap");
      do_fill("tie2_i", 1'b0, 16'h3330, 1'b0);
    end else begin
      do_fill("tie2_i", 1'b0, 16'h3330, 1'b0);
      check_idle("tie2_gap");
      do_fill("tie2_d", 1'b1, 16'h7770, 1'b0);
    end
    check_idle("tie2");

    // spurious data in IDLE
    inj_data = 16'hBEEF; inj_valid = 1'b1;
    #1;
    check("spur we",   {30'd0, i_fill_we, d_fill_we},     32'd0);
    check("spur done", {30'd0, i_fill_done, d_fill_done}, 32'd0);
    check("spur data", {16'd0, fill_data}, 32'd0);
    $display("[TB] spurious IDLE data 0xBEEF applied");
    @(negedge clk);
    inj_valid = 1'b0;

    // d_miss dropped mid-fill: block still completes
    d_miss = 1'b1; d_miss_addr = 16'h5552;
    do_fill("d_drop", 1'b1, 16'h5550, 1'b1);
    check_idle("d_drop");

    // reset during the 5th issue cycle, then trailing memory data
    i_miss = 1'b1; i_miss_addr = 16'h0808;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2;
    check("pre_rst mem_en", {31'd0, mem_en}, 32'd1);
    rst_n = 1'b0; i_miss = 1'b0;
    #1;
    check_all_zero("mid_rst");
    $display("[TB] reset asserted at 5th issue cycle");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("trail we",   {30'd0, i_fill_we, d_fill_we},     32'd0);
      check("trail done", {30'd0, i_fill_done, d_fill_done}, 32'd0);
      check("trail busy", {31'd0, busy}, 32'd0);
    end
    $display("[TB] trailing data after reset checked");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
